data_stack: RTL and testbench

DATA_STACK -- requirements
Module: data_stack

---
 rtl/data_stack.sv | 90 +++++++++
 tb/tb_data_stack.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_stack.sv
// LIFO operand stack for the core datapath: push, pop and replace-top,
// with sticky overflow/underflow flags and combinational tos/nos taps.
module data_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_err_clr,
   output logic [WIDTH-1:0]         o_tos,
   output logic [WIDTH-1:0]         o_nos,
   output logic [$clog2(DEPTH):0]   o_depth,
   output logic                     o_empty,
   output logic                     o_full,
   output logic                     o_overflow,
   output logic                     o_underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   ONE      = (AW+1)'(1);
   localparam logic [AW:0]   TWO      = (AW+1)'(2);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] IDX_ONE  = AW'(1);
   localparam logic [AW-1:0] IDX_TWO  = AW'(2);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_sp;
   logic             r_ovf;
   logic             r_unf;

   logic             w_empty;
   logic             w_full;
   logic             w_push_new;
   logic             w_pop;
   logic             w_replace;
   logic             w_ovf_ev;
   logic             w_unf_ev;
   logic [AW-1:0]    w_top_idx;
   logic [AW-1:0]    w_nos_idx;

   assign w_empty    = (r_sp == '0);
   assign w_full     = (r_sp == FULL_CNT);

   assign w_push_new = i_push & ~i_pop & ~w_full;
   assign w_ovf_ev   = i_push & ~i_pop & w_full;
   assign w_pop      = i_pop & ~i_push & ~w_empty;
   assign w_replace  = i_push & i_pop & ~w_empty;
   // Any pop on an empty stack, with or without push, is an underflow
   assign w_unf_ev   = i_pop & w_empty;

   // Low index bits wrap correctly at sp==DEPTH
   assign w_top_idx  = r_sp[AW-1:0] - IDX_ONE;
   assign w_nos_idx  = r_sp[AW-1:0] - IDX_TWO;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sp  <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         if (w_push_new)
            r_sp <= r_sp + ONE;
         else if (w_pop)
            r_sp <= r_sp - ONE;
         r_ovf <= w_ovf_ev | (r_ovf & ~i_err_clr);
         r_unf <= w_unf_ev | (r_unf & ~i_err_clr);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         if (w_push_new)
            r_mem[r_sp[AW-1:0]] <= i_push_data;
         else if (w_replace)
            r_mem[w_top_idx] <= i_push_data;
      end
   end

   assign o_tos       = w_empty ? '0 : r_mem[w_top_idx];
   assign o_nos       = (r_sp >= TWO) ? r_mem[w_nos_idx] : '0;
   assign o_depth     = r_sp;
   assign o_empty     = w_empty;
   assign o_full      = w_full;
   assign o_overflow  = r_ovf;
   assign o_underflow = r_unf;

endmodule

// File: tb/tb_data_stack.sv
// Scoreboard bench for data_stack: driver feeds a queue-based model,
// monitor compares every registered result against it.
module tb_data_stack;

   localparam int WIDTH = 16;
   localparam int DEPTH = 16;
   localparam int DW    = $clog2(DEPTH) + 1;

   typedef struct {
      logic [WIDTH-1:0] tos;
      logic [WIDTH-1:0] nos;
      logic [DW-1:0]    depth;
      logic             empty;
      logic             full;
      logic             ovf;
      logic             unf;
   } exp_t;

   logic             clk;
   logic             reset;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] push_data;
   logic             err_clr;
   logic [WIDTH-1:0] tos;
   logic [WIDTH-1:0] nos;
   logic [DW-1:0]    depth;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;

   int checks = 0;
   int errors = 0;

   exp_t             sb[$];
   logic [WIDTH-1:0] stk[$];
   logic             m_ovf = 1'b0;
   logic             m_unf = 1'b0;

   data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_push      (push),
      .i_pop       (pop),
      .i_push_data (push_data),
      .i_err_clr   (err_clr),
      .o_tos       (tos),
      .o_nos       (nos),
      .o_depth     (depth),
      .o_empty     (empty),
      .o_full      (full),
      .o_overflow  (overflow),
      .o_underflow (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", name, act, want, $time);
      end
   endtask

   // Model: a plain queue of values, top at the back
   task automatic step(input logic r, input logic pu, input logic po,
                       input logic [WIDTH-1:0] d, input logic clr);
      exp_t e;
      logic ov, un;
      @(negedge clk);
      reset = r; push = pu; pop = po; push_data = d; err_clr = clr;
      ov = 1'b0;
      un = 1'b0;
      if (r) begin
         stk.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         if (pu && !po) begin
            if (stk.size() == DEPTH) ov = 1'b1;
            else stk.push_back(d);
         end else if (po && !pu) begin
            if (stk.size() == 0) un = 1'b1;
            else void'(stk.pop_back());
         end else if (po && pu) begin
            if (stk.size() == 0) un = 1'b1;
            else stk[stk.size()-1] = d;
         end
         m_ovf = ov | (m_ovf & ~clr);
         m_unf = un | (m_unf & ~clr);
      end
      e.tos   = (stk.size() >= 1) ? stk[stk.size()-1] : '0;
      e.nos   = (stk.size() >= 2) ? stk[stk.size()-2] : '0;
      e.depth = DW'(stk.size());
      e.empty = (stk.size() == 0);
      e.full  = (stk.size() == DEPTH);
      e.ovf   = m_ovf;
      e.unf   = m_unf;
      sb.push_back(e);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic do_push(input logic [WIDTH-1:0] d);
      step(1'b0, 1'b1, 1'b0, d, 1'b0);
   endtask

   task automatic do_pop();
      step(1'b0, 1'b0, 1'b1, '0, 1'b0);
   endtask

   task automatic do_rst();
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("tos",       32'(tos),       32'(e.tos));
            chk("nos",       32'(nos),       32'(e.nos));
            chk("depth",     32'(depth),     32'(e.depth));
            chk("empty",     32'(empty),     32'(e.empty));
            chk("full",      32'(full),      32'(e.full));
            chk("overflow",  32'(overflow),  32'(e.ovf));
            chk("underflow", 32'(underflow), 32'(e.unf));
         end
      end
   end

   initial begin : driver
      int r;
      reset = 1'b1; push = 1'b0; pop = 1'b0;
      push_data = '0; err_clr = 1'b0;
      do_rst();
      do_rst();

      // Two pushes
      do_push(16'h00A5);
      do_push(16'h0012);
      idle();

      // Fill, overflow, replace at full, clear
      do_rst();
      for (int i = 0; i < DEPTH; i++) do_push(WIDTH'(i));
      do_push(16'hFFFF);
      idle();
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 16'h0077, 1'b0);
      idle();

      // Underflow, clear, clear coinciding with new underflow
      do_rst();
      do_pop();
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, 1'b1, '0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b1);
      idle();

      // Replace top
      do_rst();
      do_push(16'h0001);
      do_push(16'h0002);
      step(1'b0, 1'b1, 1'b1, 16'h0033, 1'b0);
      idle();

      // Reset mid-sequence with overflow set, colliding with a push
      do_rst();
      for (int i = 0; i < DEPTH; i++) do_push(WIDTH'(16'h0100 + i));
      do_push(16'h1234);
      for (int i = 0; i < DEPTH - 5; i++) do_pop();
      step(1'b1, 1'b1, 1'b0, 16'h0044, 1'b1);
      do_push(16'h0044);
      idle();

      // Pop the last entry
      do_pop();
      idle();

      // Randomized phases biased towards filling or draining
      do_rst();
      for (int ph = 0; ph < 40; ph++) begin
         for (int c = 0; c < 50; c++) begin
            r = int'($urandom_range(0, 99));
            if (r < 1)
               step(1'b1, 1'($urandom), 1'($urandom), WIDTH'($urandom), 1'b0);
            else if (r < 10)
               step(1'b0, 1'($urandom), 1'($urandom), WIDTH'($urandom), 1'b1);
            else if (r < 25)
               step(1'b0, 1'b1, 1'b1, WIDTH'($urandom), 1'b0);
            else if (r < 35)
               idle();
            else if ((r < 75) == ph[0])
               do_push(WIDTH'($urandom));
            else
               do_pop();
         end
      end

      idle();
      idle();
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
